// File: rtl/vector_logger.sv
// Logs {s, x} samples into a FIFO and streams each as an ASCII "<s> <x>\n" line.
// Latency: sample at edge N into an idle logger gives the first byte after N+1; lines are back-to-back.
// Backpressure: byte_data/byte_valid hold while byte_ready=0; samples arriving at a full FIFO set overflow.
module vector_logger #(
    parameter int SW    = 2,
    parameter int XW    = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_en,
    input  logic [SW-1:0]            s,
    input  logic [XW-1:0]            x,
    output logic [7:0]               byte_data,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int RW   = SW + XW;
    localparam int MAXW = (SW > XW) ? SW : XW;
    localparam int IW   = $clog2(MAXW + 1);

    typedef enum logic [2:0] {
        IDLE,
        S_BITS,
        SEP,
        X_BITS,
        EOL
    } state_t;

    logic [RW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    state_t        r_state;
    logic [SW-1:0] r_sreg;
    logic [XW-1:0] r_xreg;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_byte_data;
    logic          r_byte_valid;
    logic          r_busy;

    logic          w_xfer;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic [RW-1:0] w_head;
    logic [SW-1:0] w_sshift;
    logic [XW-1:0] w_xshift;
    state_t        w_state_nxt;
    logic [SW-1:0] w_sreg_nxt;
    logic [XW-1:0] w_xreg_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic [7:0]    w_data_nxt;
    logic [AW:0]   w_count_nxt;

    function automatic logic [7:0] f_ascii(input logic b);
        return {7'b0011000, b};
    endfunction

    // Fullness is judged on the pre-edge count, so a same-edge pop never makes room.
    assign w_xfer   = r_byte_valid & byte_ready;
    assign w_push   = sample_en && (r_count < (AW+1)'(DEPTH));
    assign w_head   = r_mem[r_rd_ptr];
    assign w_sshift = r_sreg << 1;
    assign w_xshift = r_xreg << 1;

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_xreg_nxt  = r_xreg;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_byte_data;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) w_load = 1'b1;
            end
            S_BITS: begin
                if (w_xfer) begin
                    if (r_idx == '0) begin
                        w_data_nxt  = 8'h20;
                        w_state_nxt = SEP;
                    end else begin
                        w_sreg_nxt = w_sshift;
                        w_idx_nxt  = r_idx - IW'(1);
                        w_data_nxt = f_ascii(w_sshift[SW-1]);
                    end
                end
            end
            SEP: begin
                if (w_xfer) begin
                    w_data_nxt  = f_ascii(r_xreg[XW-1]);
                    w_idx_nxt   = IW'(XW - 1);
                    w_state_nxt = X_BITS;
                end
            end
            X_BITS: begin
                if (w_xfer) begin
                    if (r_idx == '0) begin
                        w_data_nxt  = 8'h0A;
                        w_state_nxt = EOL;
                    end else begin
                        w_xreg_nxt = w_xshift;
                        w_idx_nxt  = r_idx - IW'(1);
                        w_data_nxt = f_ascii(w_xshift[XW-1]);
                    end
                end
            end
            EOL: begin
                if (w_xfer) begin
                    if (r_count != '0) begin
                        w_load = 1'b1;
                    end else begin
                        w_data_nxt  = 8'h00;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Starting a line pops the head record into the shift registers.
        if (w_load) begin
            w_pop       = 1'b1;
            w_sreg_nxt  = w_head[RW-1:XW];
            w_xreg_nxt  = w_head[XW-1:0];
            w_idx_nxt   = IW'(SW - 1);
            w_data_nxt  = f_ascii(w_head[RW-1]);
            w_state_nxt = S_BITS;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {s, x};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_sreg       <= '0;
            r_xreg       <= '0;
            r_idx        <= '0;
            r_byte_data  <= 8'h00;
            r_byte_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (sample_en && !w_push) r_overflow <= 1'b1;
            r_count      <= w_count_nxt;
            r_sreg       <= w_sreg_nxt;
            r_xreg       <= w_xreg_nxt;
            r_idx        <= w_idx_nxt;
            r_byte_data  <= w_data_nxt;
            r_byte_valid <= (w_state_nxt != IDLE);
            r_busy       <= (w_state_nxt != IDLE) || (w_count_nxt != '0);
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule

// File: tb/tb_vector_logger.sv
// Self-checking bench for vector_logger: directed scenarios plus random traffic against a line-level model.
module tb_vector_logger;

    localparam int SW    = 2;
    localparam int XW    = 1;
    localparam int DEPTH = 8;
    localparam int RW    = SW + XW;
    localparam int LB    = SW + XW + 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          sample_en = 1'b0;
    logic [SW-1:0] s = '0;
    logic [XW-1:0] x = '0;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready = 1'b0;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;

    // Model: queued records, bytes still to send of the current line, sticky overflow.
    logic [RW-1:0] m_q[$];
    logic [7:0]    m_line[$];
    bit            m_ovf;
    logic [7:0]    got[$];
    logic [7:0]    exp_q[$];

    vector_logger #(.SW(SW), .XW(XW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .s(s), .x(x),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .count(count), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] line_byte(input logic [RW-1:0] r, input int k);
        logic [SW-1:0] sv;
        logic [XW-1:0] xv;
        sv = r[RW-1:XW];
        xv = r[XW-1:0];
        if (k < SW)                return sv[SW-1-k] ? 8'h31 : 8'h30;
        else if (k == SW)          return 8'h20;
        else if (k < SW + 1 + XW)  return xv[XW-1-(k-SW-1)] ? 8'h31 : 8'h30;
        else                       return 8'h0A;
    endfunction

    task automatic add_exp(input logic [SW-1:0] sv, input logic [XW-1:0] xv);
        for (int k = 0; k < LB; k++) exp_q.push_back(line_byte({sv, xv}, k));
    endtask

    task automatic model_edge(input logic se, input logic [SW-1:0] sv,
                              input logic [XW-1:0] xv, input logic rdy);
        bit can_push;
        logic [RW-1:0] r;
        can_push = se && (m_q.size() < DEPTH);
        if (m_line.size() != 0 && rdy) void'(m_line.pop_front());
        if (m_line.size() == 0 && m_q.size() != 0) begin
            r = m_q.pop_front();
            for (int k = 0; k < LB; k++) m_line.push_back(line_byte(r, k));
        end
        if (can_push) m_q.push_back({sv, xv});
        else if (se)  m_ovf = 1'b1;
    endtask

    task automatic compare_all();
        chk("valid", 32'(byte_valid), 32'(m_line.size() != 0));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'((m_line.size() != 0) || (m_q.size() != 0)));
        if (m_line.size() != 0) chk("data", 32'(byte_data), 32'(m_line[0]));
    endtask

    task automatic step(input logic se, input logic [SW-1:0] sv,
                        input logic [XW-1:0] xv, input logic rdy);
        sample_en  = se;
        s          = sv;
        x          = xv;
        byte_ready = rdy;
        if (byte_valid && byte_ready) got.push_back(byte_data);
        @(posedge clk);
        model_edge(se, sv, xv, rdy);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_en = 1'b0;
        byte_ready = 1'b0;
        #1;
        m_q.delete();
        m_line.delete();
        m_ovf = 1'b0;
        chk("rst_data", 32'(byte_data), 32'h00);
        chk("rst_valid", 32'(byte_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        exp_q.delete();
    endtask

    task automatic check_got(input string tag);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(tag, 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (busy || byte_valid); i++) step(1'b0, '0, '0, 1'b1);
        chk("drain_idle", 32'(busy), 32'h0);
    endtask

    initial begin
        #2;
        // Single record, ready held high.
        do_reset();
        step(1'b1, 2'b10, 1'b1, 1'b1);
        chk("single_valid_after_push", 32'(byte_valid), 32'h0);
        chk("single_count_after_push", 32'(count), 32'h1);
        chk("single_busy_after_push", 32'(busy), 32'h1);
        step(1'b0, '0, '0, 1'b1);
        chk("single_first_byte", 32'(byte_data), 32'h31);
        chk("single_valid_rise", 32'(byte_valid), 32'h1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1);
        chk("single_busy_end", 32'(busy), 32'h0);
        chk("single_count_end", 32'(count), 32'h0);
        exp_q = '{8'h31, 8'h30, 8'h20, 8'h31, 8'h0A};
        check_got("single_bytes");

        // Backpressure on the second byte.
        do_reset();
        step(1'b1, 2'b10, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b0);
            chk("bp_hold_data", 32'(byte_data), 32'h30);
            chk("bp_hold_valid", 32'(byte_valid), 32'h1);
        end
        drain(20);
        exp_q = '{8'h31, 8'h30, 8'h20, 8'h31, 8'h0A};
        check_got("bp_bytes");

        // Overflow: ten samples with the sink stalled.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, SW'(i % 4), XW'(i % 2), 1'b0);
            if (i < 9) add_exp(SW'(i % 4), XW'(i % 2));
        end
        chk("ovf_count", 32'(count), 32'h8);
        chk("ovf_flag", 32'(overflow), 32'h1);
        drain(100);
        check_got("ovf_drain");
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Back-to-back lines.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            logic [SW-1:0] sv;
            logic [XW-1:0] xv;
            sv = SW'($urandom);
            xv = XW'($urandom);
            add_exp(sv, xv);
            step(1'b1, sv, xv, 1'b1);
        end
        for (int i = 0; i < 14; i++) begin
            chk("b2b_no_gap", 32'(byte_valid), 32'h1);
            step(1'b0, '0, '0, 1'b1);
        end
        chk("b2b_valid_end", 32'(byte_valid), 32'h0);
        check_got("b2b_bytes");

        // Simultaneous EOL pop and sample at full.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, SW'(i), XW'(i), 1'b0);
        chk("full_count", 32'(count), 32'h8);
        chk("full_no_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1);
        chk("full_at_eol", 32'(byte_data), 32'h0A);
        step(1'b1, 2'b11, 1'b1, 1'b1);
        chk("full_pop_count", 32'(count), 32'h7);
        chk("full_pop_ovf", 32'(overflow), 32'h1);

        // Asynchronous reset partway through a line.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, SW'(i), XW'(i), 1'b0);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        do_reset();
        step(1'b1, 2'b01, 1'b0, 1'b1);
        drain(20);
        exp_q = '{8'h30, 8'h31, 8'h20, 8'h30, 8'h0A};
        check_got("post_rst_bytes");

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 3, SW'($urandom), XW'($urandom), $urandom_range(0, 9) < 7);
        drain(200);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
